ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter
//
// Shares one byte-wide, single-port, synchronous-read RAM between an
// instruction-fetch port (always 4-byte reads) and a load/store port
// (1, 2 or 4 byte reads or writes). Multi-byte accesses are split into
// consecutive byte cycles at base, base+1, ... (wrapping modulo the address
// space). Read data is assembled little-endian and zero-extended.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   if_req/if_addr        fetch request (word read) and byte address
//   if_done/if_rdata      one-cycle completion pulse and fetched word
//   ls_req/ls_we/ls_addr  load/store request, 1 = store, byte address
//   ls_size/ls_wdata      00 byte, 01 half, 1x word; store data
//   ls_done/ls_rdata      one-cycle completion pulse and load data
//   ram_we/ram_addr/ram_din   RAM write enable, byte address, write data
//   ram_dout              RAM read data for the address of the previous cycle
//
// All outputs are registered; every output is forced low by reset without
// waiting for a clock edge.

module ram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Instruction-fetch port
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_rdata,
  // Load/store port
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [1:0]            ls_size,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_done,
  output logic [31:0]           ls_rdata,
  // RAM port
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_din,
  input  logic [7:0]            ram_dout
);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRdLast,
    StWr,
    StResp
  } state_e;

  state_e                state_q, state_d;
  logic                  own_ls_q, own_ls_d;     // owner of the current transaction
  logic                  last_ls_q, last_ls_d;   // last grant went to load/store
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;         // latched base address
  logic [1:0]            last_q, last_d;         // index of the final byte (N-1)
  logic [31:0]           wdata_q, wdata_d;
  logic [1:0]            cnt_q, cnt_d;           // byte index i
  logic [31:0]           buf_q, buf_d;           // read assembly buffer
  logic [31:0]           if_rdata_q, if_rdata_d;
  logic [31:0]           ls_rdata_q, ls_rdata_d;
  logic                  if_done_q, if_done_d;
  logic                  ls_done_q, ls_done_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]            ram_din_q, ram_din_d;

  logic                  grant_ls;
  logic                  nxt_we;
  logic [31:0]           rd_word;

  // On a tie the requester that did not win last time is granted.
  assign grant_ls = ls_req & (~if_req | ~last_ls_q);

  always_comb begin
    state_d    = state_q;
    own_ls_d   = own_ls_q;
    last_ls_d  = last_ls_q;
    addr_d     = addr_q;
    last_d     = last_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = '0;
    ram_din_d  = 8'h00;
    nxt_we     = 1'b0;

    // Completed read word: buffer plus the byte arriving this cycle. Bytes
    // above N-1 stay zero because the buffer is cleared at grant.
    rd_word = buf_q;
    rd_word[{last_q, 3'b000} +: 8] = ram_dout;

    unique case (state_q)
      StIdle: begin
        if (if_req || ls_req) begin
          own_ls_d  = grant_ls;
          last_ls_d = grant_ls;
          cnt_d     = 2'd0;
          buf_d     = 32'h0;
          if (grant_ls) begin
            addr_d  = ls_addr;
            wdata_d = ls_wdata;
            nxt_we  = ls_we;
            unique case (ls_size)
              2'b00:   last_d = 2'd0;
              2'b01:   last_d = 2'd1;
              default: last_d = 2'd3;
            endcase
          end else begin
            addr_d  = if_addr;
            wdata_d = 32'h0;
            nxt_we  = 1'b0;
            last_d  = 2'd3;
          end
          // Outputs are registered, so the first byte access is set up here.
          ram_addr_d = addr_d;
          if (nxt_we) begin
            state_d   = StWr;
            ram_we_d  = 1'b1;
            ram_din_d = wdata_d[7:0];
          end else begin
            state_d = StRd;
          end
        end
      end

      StRd: begin
        // ram_dout now holds the byte addressed in the previous cycle.
        if (cnt_q != 2'd0) begin
          buf_d[{cnt_q - 2'd1, 3'b000} +: 8] = ram_dout;
        end
        if (cnt_q == last_q) begin
          state_d = StRdLast;
        end else begin
          cnt_d      = cnt_q + 2'd1;
          ram_addr_d = addr_q + ADDR_WIDTH'(cnt_d);
        end
      end

      StRdLast: begin
        buf_d   = rd_word;
        state_d = StResp;
        if (own_ls_q) begin
          ls_rdata_d = rd_word;
          ls_done_d  = 1'b1;
        end else begin
          if_rdata_d = rd_word;
          if_done_d  = 1'b1;
        end
      end

      StWr: begin
        if (cnt_q == last_q) begin
          state_d = StResp;
          if (own_ls_q) begin
            ls_done_d = 1'b1;
          end else begin
            if_done_d = 1'b1;
          end
        end else begin
          cnt_d      = cnt_q + 2'd1;
          ram_we_d   = 1'b1;
          ram_addr_d = addr_q + ADDR_WIDTH'(cnt_d);
          ram_din_d  = wdata_q[{cnt_d, 3'b000} +: 8];
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      own_ls_q   <= 1'b0;
      last_ls_q  <= 1'b0;
      addr_q     <= '0;
      last_q     <= 2'd0;
      wdata_q    <= 32'h0;
      cnt_q      <= 2'd0;
      buf_q      <= 32'h0;
      if_rdata_q <= 32'h0;
      ls_rdata_q <= 32'h0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      own_ls_q   <= own_ls_d;
      last_ls_q  <= last_ls_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
    end
  end

  assign if_done  = if_done_q;
  assign if_rdata = if_rdata_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: a byte RAM model attached to the RAM port and a
// transaction-level reference memory that predicts load data, latency and
// the byte-address sequence of each access.

module tb_ram_arbiter;

  localparam int unsigned AW = 17;
  localparam int unsigned MEM_SIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [31:0]   if_rdata;
  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [1:0]    ls_size;
  logic [31:0]   ls_wdata;
  logic          ls_done;
  logic [31:0]   ls_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din;
  logic [7:0]    ram_dout;

  int errors = 0;
  int checks = 0;

  logic [7:0]    mem     [0:MEM_SIZE-1];
  logic [7:0]    ref_mem [0:MEM_SIZE-1];
  logic [AW-1:0] tr_addr [0:20];
  logic          tr_we   [0:20];
  logic [7:0]    tr_din  [0:20];
  logic [31:0]   exp_if_rdata = 32'h0;
  logic [31:0]   exp_ls_rdata = 32'h0;

  ram_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_done  (if_done),
    .if_rdata (if_rdata),
    .ls_req   (ls_req),
    .ls_we    (ls_we),
    .ls_addr  (ls_addr),
    .ls_size  (ls_size),
    .ls_wdata (ls_wdata),
    .ls_done  (ls_done),
    .ls_rdata (ls_rdata),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // Synchronous-read, synchronous-write byte RAM.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int n_of(input logic [1:0] size);
    if (size == 2'b00) return 1;
    if (size == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [AW-1:0] addr, input int n);
    logic [31:0]   w = 32'h0;
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = addr + AW'(i);
      w = w | (32'(ref_mem[a]) << (8 * i));
    end
    return w;
  endfunction

  task automatic ref_store(input logic [AW-1:0] addr, input int n, input logic [31:0] wd);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = addr + AW'(i);
      ref_mem[a] = 8'(wd >> (8 * i));
    end
  endtask

  // Issue one transaction from the IDLE cycle and watch until its done pulse.
  // lat is the cycle index of done (cycle 0 = sampling cycle), -1 on timeout.
  task automatic run_txn(input bit is_ls, input bit we, input logic [AW-1:0] addr,
                         input logic [1:0] size, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output bit stray);
    @(negedge clk);
    if (is_ls) begin
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_size = size; ls_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    lat = -1; rd = 32'h0; stray = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      tr_addr[k] = ram_addr; tr_we[k] = ram_we; tr_din[k] = ram_din;
      if ((is_ls && if_done) || (!is_ls && ls_done)) stray = 1'b1;
      if ((is_ls && ls_done) || (!is_ls && if_done)) begin
        lat = k;
        rd  = is_ls ? ls_rdata : if_rdata;
        break;
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({ram_we, ram_addr, ram_din, if_done, ls_done, if_rdata, ls_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b addr=%h din=%h dones=%b%b ifr=%h lsr=%h, required all 0",
               ram_we, ram_addr, ram_din, if_done, ls_done, if_rdata, ls_rdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ram_we, ram_addr, if_done, ls_done} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got we=%b addr=%h dones=%b%b, required all 0",
               ram_we, ram_addr, if_done, ls_done);
    end
  endtask

  task automatic test_if_fetch();
    int lat; logic [31:0] rd; bit stray;
    mem[17'h10] = 8'h11; mem[17'h11] = 8'h22; mem[17'h12] = 8'h33; mem[17'h13] = 8'h44;
    ref_mem[17'h10] = 8'h11; ref_mem[17'h11] = 8'h22;
    ref_mem[17'h12] = 8'h33; ref_mem[17'h13] = 8'h44;
    run_txn(1'b0, 1'b0, 17'h10, 2'b10, 32'h0, lat, rd, stray);
    checks++;
    if (lat !== 6) begin
      errors++; $display("FAIL fetch_latency: got %0d, required 6", lat);
    end
    checks++;
    if (rd !== 32'h44332211) begin
      errors++; $display("FAIL fetch_data: got %h, required 44332211", rd);
    end
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (tr_addr[k] !== 17'(32'h10 + k - 1) || tr_we[k] !== 1'b0) begin
        errors++;
        $display("FAIL fetch_addr_c%0d: got addr=%h we=%b, required addr=%h we=0",
                 k, tr_addr[k], tr_we[k], 17'(32'h10 + k - 1));
      end
    end
    checks++;
    if (tr_addr[5] !== 17'h0) begin
      errors++; $display("FAIL fetch_addr_idle: got %h, required 0", tr_addr[5]);
    end
    exp_if_rdata = 32'h44332211;
  endtask

  task automatic test_store_byte();
    int lat; logic [31:0] rd; bit stray;
    run_txn(1'b1, 1'b1, 17'h20, 2'b00, 32'hAABBCCDD, lat, rd, stray);
    ref_store(17'h20, 1, 32'hAABBCCDD);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL store_latency: got %0d, required 2", lat);
    end
    checks++;
    if (tr_we[1] !== 1'b1 || tr_addr[1] !== 17'h20 || tr_din[1] !== 8'hDD) begin
      errors++;
      $display("FAIL store_cycle: got we=%b addr=%h din=%h, required we=1 addr=00020 din=dd",
               tr_we[1], tr_addr[1], tr_din[1]);
    end
    checks++;
    if (tr_we[2] !== 1'b0) begin
      errors++; $display("FAIL store_single_we: got we=%b in done cycle, required 0", tr_we[2]);
    end
    checks++;
    if (ls_rdata !== exp_ls_rdata) begin
      errors++; $display("FAIL store_keeps_rdata: got %h, required %h", ls_rdata, exp_ls_rdata);
    end
    run_txn(1'b1, 1'b0, 17'h20, 2'b00, 32'h0, lat, rd, stray);
    checks++;
    if (lat !== 3 || rd !== 32'h000000DD) begin
      errors++; $display("FAIL byte_load: got lat=%0d data=%h, required lat=3 data=000000dd", lat, rd);
    end
    exp_ls_rdata = 32'h000000DD;
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] rd; bit stray;
    logic [31:0] exp;
    logic [AW-1:0] ea [0:3];
    ea[0] = 17'h1FFFE; ea[1] = 17'h1FFFF; ea[2] = 17'h00000; ea[3] = 17'h00001;
    exp = ref_load(17'h1FFFE, 4);
    run_txn(1'b1, 1'b0, 17'h1FFFE, 2'b10, 32'h0, lat, rd, stray);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (tr_addr[k] !== ea[k-1]) begin
        errors++; $display("FAIL wrap_addr_c%0d: got %h, required %h", k, tr_addr[k], ea[k-1]);
      end
    end
    checks++;
    if (lat !== 6 || rd !== exp) begin
      errors++; $display("FAIL wrap_load: got lat=%0d data=%h, required lat=6 data=%h", lat, rd, exp);
    end
    exp_ls_rdata = exp;
  endtask

  task automatic test_tie();
    string seq = "";
    bit prev_if = 1'b0, prev_ls = 1'b0;
    logic [31:0] exp_i, exp_l;
    exp_i = ref_load(17'h100, 4);
    exp_l = ref_load(17'h200, 4);
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 17'h100;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 17'h200; ls_size = 2'b10; ls_wdata = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 60 && seq.len() < 4; k++) begin
      @(negedge clk);
      if (prev_if) begin
        checks++;
        if (if_done !== 1'b0) begin errors++; $display("FAIL tie_if_pulse: got 2-cycle done, required 1"); end
      end
      if (prev_ls) begin
        checks++;
        if (ls_done !== 1'b0) begin errors++; $display("FAIL tie_ls_pulse: got 2-cycle done, required 1"); end
      end
      if (if_done && ls_done) begin
        checks++; errors++; $display("FAIL tie_both_done: got both pulses, required at most one");
      end
      if (if_done) begin
        seq = {seq, "I"};
        checks++;
        if (if_rdata !== exp_i) begin errors++; $display("FAIL tie_if_data: got %h, required %h", if_rdata, exp_i); end
      end
      if (ls_done) begin
        seq = {seq, "L"};
        checks++;
        if (ls_rdata !== exp_l) begin errors++; $display("FAIL tie_ls_data: got %h, required %h", ls_rdata, exp_l); end
      end
      prev_if = if_done; prev_ls = ls_done;
    end
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_done !== 1'b0 || ls_done !== 1'b0) begin
      errors++; $display("FAIL tie_last_pulse: got dones=%b%b, required 00", if_done, ls_done);
    end
    checks++;
    if (seq != "LILI") begin
      errors++; $display("FAIL tie_order: got '%s', required 'LILI'", seq);
    end
    exp_if_rdata = exp_i;
    exp_ls_rdata = exp_l;
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; bit stray;
    bit seen_done = 1'b0;
    logic [31:0] exp;
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 17'h40; ls_size = 2'b10; ls_wdata = 32'h5A6B7C8D;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 17'h41) begin
      errors++; $display("FAIL abort_wr2: got we=%b addr=%h, required we=1 addr=00041", ram_we, ram_addr);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_we, ram_addr, ram_din, if_done, ls_done, if_rdata, ls_rdata} !== '0) begin
      errors++;
      $display("FAIL abort_async: got we=%b addr=%h din=%h dones=%b%b ifr=%h lsr=%h, required all 0",
               ram_we, ram_addr, ram_din, if_done, ls_done, if_rdata, ls_rdata);
    end
    ls_req = 1'b0;
    ref_store(17'h40, 2, 32'h5A6B7C8D);
    exp_if_rdata = 32'h0;
    exp_ls_rdata = 32'h0;
    repeat (3) begin
      @(negedge clk);
      if (ls_done || if_done) seen_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ls_done || if_done) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin errors++; $display("FAIL abort_no_done: got a done pulse, required none"); end
    checks++;
    if (mem[17'h41] !== ref_mem[17'h41] || mem[17'h42] !== ref_mem[17'h42]) begin
      errors++;
      $display("FAIL abort_partial: got ram[41]=%h ram[42]=%h, required %h %h",
               mem[17'h41], mem[17'h42], ref_mem[17'h41], ref_mem[17'h42]);
    end
    exp = ref_load(17'h40, 4);
    run_txn(1'b1, 1'b0, 17'h40, 2'b10, 32'h0, lat, rd, stray);
    checks++;
    if (lat !== 6 || rd !== exp) begin
      errors++; $display("FAIL abort_reissue: got lat=%0d data=%h, required lat=6 data=%h", lat, rd, exp);
    end
    exp_ls_rdata = exp;
  endtask

  task automatic test_random();
    int lat, n, elat, bad;
    logic [31:0] rd, wd, exp;
    logic [AW-1:0] addr;
    logic [1:0] size;
    bit is_ls, we, stray;
    for (int t = 0; t < 40; t++) begin
      is_ls = 1'($urandom_range(0, 1));
      we    = is_ls ? 1'($urandom_range(0, 1)) : 1'b0;
      size  = 2'($urandom_range(0, 3));
      addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(32'h1FFFC, 32'h1FFFF))
                                          : AW'($urandom_range(32'h300, 32'h33F));
      wd    = $urandom;
      n     = is_ls ? n_of(size) : 4;
      elat  = we ? n + 1 : n + 2;
      exp   = ref_load(addr, n);
      run_txn(is_ls, we, addr, size, wd, lat, rd, stray);
      checks++;
      if (lat !== elat || stray) begin
        errors++;
        $display("FAIL rand%0d_latency: got lat=%0d stray=%b, required lat=%0d stray=0",
                 t, lat, stray, elat);
      end
      if (we) begin
        ref_store(addr, n, wd);
      end else begin
        checks++;
        if (rd !== exp) begin
          errors++; $display("FAIL rand%0d_data: got %h, required %h", t, rd, exp);
        end
        if (is_ls) exp_ls_rdata = exp; else exp_if_rdata = exp;
      end
      checks++;
      if (if_rdata !== exp_if_rdata || ls_rdata !== exp_ls_rdata) begin
        errors++;
        $display("FAIL rand%0d_hold: got if=%h ls=%h, required if=%h ls=%h",
                 t, if_rdata, ls_rdata, exp_if_rdata, exp_ls_rdata);
      end
    end
    @(negedge clk);
    bad = 0;
    for (int a = 32'h300; a < 32'h340; a++) if (mem[a] !== ref_mem[a]) bad++;
    for (int a = 32'h1FFFC; a < 32'h20000; a++) if (mem[a] !== ref_mem[a]) bad++;
    for (int a = 0; a < 4; a++) if (mem[a] !== ref_mem[a]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rand_ram_contents: got %0d differing bytes, required 0", bad);
    end
  endtask

  initial begin
    logic [7:0] v;
    for (int i = 0; i < MEM_SIZE; i++) begin
      v = 8'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_size = 2'b00; ls_wdata = 32'h0;
    test_reset();
    test_if_fetch();
    test_store_byte();
    test_wrap();
    test_tie();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
